// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, runs a
// variable-latency imem request handshake, buffers words across stalls and squashes on branches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        LE_PC,
    input  logic        LE_IF_ID,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] old_addr_reg;
    logic [31:0] buf_instr_reg;
    logic [31:0] buf_pc4_reg;
    logic        active_reg;

    logic        stall;
    logic        accept;
    logic [31:0] pc_plus4;

    assign stall    = ~LE_PC | ~LE_IF_ID;
    assign pc_plus4 = pc_reg + 32'd4;

    // active_reg keeps the request low through reset and the release edge,
    // so a response to an abandoned request can never be accepted.
    assign imem_req  = active_reg && (state_reg != HOLD);
    assign imem_addr = (state_reg == DISCARD) ? old_addr_reg : pc_reg;
    assign accept    = imem_req & imem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= FETCH;
            pc_reg        <= RESET_PC;
            old_addr_reg  <= 32'd0;
            buf_instr_reg <= 32'd0;
            buf_pc4_reg   <= 32'd0;
            active_reg    <= 1'b0;
            if_id_instr   <= NOP_WORD;
            if_id_pc4     <= 32'd0;
            if_id_valid   <= 1'b0;
        end else begin
            active_reg <= 1'b1;
            if (branch_taken) begin
                pc_reg      <= branch_target;
                if_id_instr <= NOP_WORD;
                if_id_pc4   <= 32'd0;
                if_id_valid <= 1'b0;
                // An unanswered request must still be seen through at its old address.
                if (imem_req && !imem_ready) begin
                    state_reg    <= DISCARD;
                    old_addr_reg <= imem_addr;
                end else begin
                    state_reg <= FETCH;
                end
            end else begin
                case (state_reg)
                    FETCH: begin
                        if (accept) begin
                            if (!stall) begin
                                if_id_instr <= imem_rdata;
                                if_id_pc4   <= pc_plus4;
                                if_id_valid <= 1'b1;
                                pc_reg      <= pc_plus4;
                            end else begin
                                buf_instr_reg <= imem_rdata;
                                buf_pc4_reg   <= pc_plus4;
                                state_reg     <= HOLD;
                            end
                        end else if (!stall) begin
                            if_id_instr <= NOP_WORD;
                            if_id_pc4   <= 32'd0;
                            if_id_valid <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            if_id_instr <= buf_instr_reg;
                            if_id_pc4   <= buf_pc4_reg;
                            if_id_valid <= 1'b1;
                            pc_reg      <= pc_plus4;
                            state_reg   <= FETCH;
                        end
                    end
                    DISCARD: begin
                        if (!stall) begin
                            if_id_instr <= NOP_WORD;
                            if_id_pc4   <= 32'd0;
                            if_id_valid <= 1'b0;
                        end
                        if (accept) begin
                            state_reg <= FETCH;
                        end
                    end
                    default: begin
                        state_reg <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, zero-wait and two-cycle memory,
// stall/HOLD recovery, branch squash from FETCH/HOLD/DISCARD, reset during DISCARD, PC wrap.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        LE_PC;
    logic        LE_IF_ID;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int tests_run;
    int tests_failed;

    fetch_stage #(
        .RESET_PC(RST_PC),
        .NOP_WORD(NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .LE_PC        (LE_PC),
        .LE_IF_ID     (LE_IF_ID),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; LE_PC = 1'b1; LE_IF_ID = 1'b1;
        branch_taken = 1'b0; branch_target = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; LE_PC = 1'b1; LE_IF_ID = 1'b1;
        branch_taken = 1'b0; branch_target = 32'd0;
        imem_ready = 1'b1; imem_rdata = 32'h100;
        step(); step();
        tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
        tests_run++; if (if_id_instr !== NOP) begin tests_failed++; $display("FAIL rst_instr got %h exp %h", if_id_instr, NOP); end
        tests_run++; if (if_id_pc4 !== 32'd0) begin tests_failed++; $display("FAIL rst_pc4 got %h exp 0", if_id_pc4); end
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req got %b exp 0", imem_req); end
        rst_n = 1'b1;
        step();
        tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL rel_req got %b exp 1", imem_req); end
        tests_run++; if (imem_addr !== RST_PC) begin tests_failed++; $display("FAIL rel_addr got %h exp %h", imem_addr, RST_PC); end
        tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL rel_valid got %b exp 0", if_id_valid); end
        for (int i = 0; i < 4; i++) begin
            imem_rdata = imem_addr + 32'h100;
            step();
            tests_run++; if (if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL zw_valid[%0d] got %b exp 1", i, if_id_valid); end
            tests_run++; if (if_id_pc4 !== 32'(4 * (i + 1))) begin tests_failed++; $display("FAIL zw_pc4[%0d] got %h exp %h", i, if_id_pc4, 32'(4 * (i + 1))); end
            tests_run++; if (if_id_instr !== 32'(4 * i + 256)) begin tests_failed++; $display("FAIL zw_instr[%0d] got %h exp %h", i, if_id_instr, 32'(4 * i + 256)); end
            $display("[TB] zero-wait fetch %0d pc4=%h instr=%h", i, if_id_pc4, if_id_instr);
        end
    endtask

    task automatic test_two_cycle();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            imem_ready = 1'b0; imem_rdata = 32'hFFFF_FFFF;
            step();
            tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL tc_gap_valid[%0d] got %b exp 0", k, if_id_valid); end
            tests_run++; if (imem_addr !== 32'(4 * k)) begin tests_failed++; $display("FAIL tc_addr_hold[%0d] got %h exp %h", k, imem_addr, 32'(4 * k)); end
            imem_ready = 1'b1; imem_rdata = 32'h200 + 32'(k);
            step();
            tests_run++; if (if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL tc_valid[%0d] got %b exp 1", k, if_id_valid); end
            tests_run++; if (if_id_instr !== 32'h200 + 32'(k)) begin tests_failed++; $display("FAIL tc_instr[%0d] got %h exp %h", k, if_id_instr, 32'h200 + 32'(k)); end
            tests_run++; if (if_id_pc4 !== 32'(4 * k + 4)) begin tests_failed++; $display("FAIL tc_pc4[%0d] got %h exp %h", k, if_id_pc4, 32'(4 * k + 4)); end
            tests_run++; if (imem_addr !== 32'(4 * k + 4)) begin tests_failed++; $display("FAIL tc_addr_next[%0d] got %h exp %h", k, imem_addr, 32'(4 * k + 4)); end
            $display("[TB] two-cycle fetch %0d pc4=%h instr=%h", k, if_id_pc4, if_id_instr);
        end
    endtask

    task automatic test_hold();
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            imem_rdata = imem_addr + 32'h100;
            step();
        end
        LE_PC = 1'b0; LE_IF_ID = 1'b0; imem_rdata = 32'hE081_1002;
        step();
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL hold_req got %b exp 0", imem_req); end
        tests_run++; if (if_id_pc4 !== 32'd8 || if_id_instr !== 32'h104) begin tests_failed++; $display("FAIL hold_ifid got %h/%h exp 104/8", if_id_instr, if_id_pc4); end
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'hBAD0_0000 + 32'(i);
            step();
            tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL hold_req_cyc[%0d] got %b exp 0", i, imem_req); end
            tests_run++; if (if_id_pc4 !== 32'd8) begin tests_failed++; $display("FAIL hold_pc4_cyc[%0d] got %h exp 8", i, if_id_pc4); end
        end
        LE_PC = 1'b1; LE_IF_ID = 1'b1; imem_rdata = 32'hBAD0_00FF;
        step();
        tests_run++; if (if_id_instr !== 32'hE081_1002) begin tests_failed++; $display("FAIL rel_instr got %h exp e0811002", if_id_instr); end
        tests_run++; if (if_id_pc4 !== 32'd12) begin tests_failed++; $display("FAIL rel_pc4 got %h exp c", if_id_pc4); end
        tests_run++; if (if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL rel_valid2 got %b exp 1", if_id_valid); end
        tests_run++; if (imem_addr !== 32'd12 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL rel_addr2 got %h req %b exp c req 1", imem_addr, imem_req); end
        imem_rdata = 32'h10C;
        step();
        tests_run++; if (if_id_instr !== 32'h10C || if_id_pc4 !== 32'd16) begin tests_failed++; $display("FAIL post_hold got %h/%h exp 10c/10", if_id_instr, if_id_pc4); end
        $display("[TB] hold recovery instr=%h pc4=%h", if_id_instr, if_id_pc4);
    endtask

    task automatic test_branch_discard();
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = imem_addr + 32'h100;
            step();
        end
        tests_run++; if (imem_addr !== 32'h10) begin tests_failed++; $display("FAIL bd_setup got %h exp 10", imem_addr); end
        imem_ready = 1'b0;
        step();
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        tests_run++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc4 !== 32'd0) begin tests_failed++; $display("FAIL bd_bubble got %h/%h/%b exp %h/0/0", if_id_instr, if_id_pc4, if_id_valid, NOP); end
        tests_run++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL bd_addr got %h req %b exp 10 req 1", imem_addr, imem_req); end
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        tests_run++; if (if_id_valid !== 1'b0 || if_id_instr === 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL bd_drop got %h valid %b exp %h valid 0", if_id_instr, if_id_valid, NOP); end
        tests_run++; if (imem_addr !== 32'h40) begin tests_failed++; $display("FAIL bd_newaddr got %h exp 40", imem_addr); end
        imem_rdata = 32'h140;
        step();
        tests_run++; if (if_id_instr !== 32'h140 || if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL bd_target got %h/%h/%b exp 140/44/1", if_id_instr, if_id_pc4, if_id_valid); end
        $display("[TB] branch discard target fetch instr=%h pc4=%h", if_id_instr, if_id_pc4);
    endtask

    task automatic test_branch_hold();
        do_reset();
        imem_ready = 1'b1; imem_rdata = 32'h100;
        step();
        LE_PC = 1'b0; LE_IF_ID = 1'b0; imem_rdata = 32'h1111_1111;
        step();
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bh_inhold got req %b exp 0", imem_req); end
        branch_taken = 1'b1; branch_target = 32'h80;
        step();
        branch_taken = 1'b0; LE_PC = 1'b1; LE_IF_ID = 1'b1;
        tests_run++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc4 !== 32'd0) begin tests_failed++; $display("FAIL bh_bubble got %h/%h/%b exp %h/0/0", if_id_instr, if_id_pc4, if_id_valid, NOP); end
        tests_run++; if (imem_addr !== 32'h80 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL bh_addr got %h req %b exp 80 req 1", imem_addr, imem_req); end
        imem_rdata = 32'h180;
        step();
        tests_run++; if (if_id_instr !== 32'h180 || if_id_pc4 !== 32'h84) begin tests_failed++; $display("FAIL bh_next got %h/%h exp 180/84", if_id_instr, if_id_pc4); end
        $display("[TB] branch over hold instr=%h pc4=%h", if_id_instr, if_id_pc4);
    endtask

    task automatic test_reset_discard();
        do_reset();
        imem_ready = 1'b1; imem_rdata = 32'h100;
        step();
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h20;
        step();
        branch_taken = 1'b0;
        tests_run++; if (imem_addr !== 32'd4) begin tests_failed++; $display("FAIL rd_setup got %h exp 4", imem_addr); end
        rst_n = 1'b0;
        step();
        tests_run++; if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin tests_failed++; $display("FAIL rd_req got %b addr %h exp 0 addr %h", imem_req, imem_addr, RST_PC); end
        tests_run++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc4 !== 32'd0) begin tests_failed++; $display("FAIL rd_ifid got %h/%h/%b exp %h/0/0", if_id_instr, if_id_pc4, if_id_valid, NOP); end
        rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        step();
        tests_run++; if (if_id_valid !== 1'b0 || imem_addr !== RST_PC || imem_req !== 1'b1) begin tests_failed++; $display("FAIL rd_late got valid %b addr %h req %b exp 0/%h/1", if_id_valid, imem_addr, imem_req, RST_PC); end
        imem_rdata = 32'h100;
        step();
        tests_run++; if (if_id_instr !== 32'h100 || if_id_pc4 !== 32'd4 || if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL rd_first got %h/%h/%b exp 100/4/1", if_id_instr, if_id_pc4, if_id_valid); end
        $display("[TB] reset during discard first fetch instr=%h", if_id_instr);
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1'b1; imem_rdata = 32'h100;
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        tests_run++; if (if_id_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wr_branch got valid %b addr %h exp 0/fffffffc", if_id_valid, imem_addr); end
        imem_rdata = 32'h55;
        step();
        tests_run++; if (if_id_instr !== 32'h55 || if_id_pc4 !== 32'd0 || if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL wr_pc4 got %h/%h/%b exp 55/0/1", if_id_instr, if_id_pc4, if_id_valid); end
        tests_run++; if (imem_addr !== 32'd0) begin tests_failed++; $display("FAIL wr_addr got %h exp 0", imem_addr); end
        $display("[TB] wrap fetch pc4=%h addr=%h", if_id_pc4, imem_addr);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_two_cycle();
        test_hold();
        test_branch_discard();
        test_branch_hold();
        test_reset_discard();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
